// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
package div_pkg;

    localparam int N_W_DEF = 16;
    localparam int D_W_DEF = 8;
    localparam int CNT_W   = $clog2(N_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Results reported when the divisor is zero
    localparam logic [N_W_DEF-1:0] Q_DZ = '1;
    localparam logic [D_W_DEF-1:0] R_DZ = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int D_W = D_W_DEF
) (
    input  logic [D_W:0]   P_in,
    input  logic           n_bit,
    input  logic [D_W-1:0] D,
    output logic [D_W:0]   P_out,
    output logic           q_bit
);

    logic [D_W:0] p_shift;

    // P_in is always below D, so its top bit is zero and dropping it loses nothing
    assign p_shift = {P_in[D_W-1:0], n_bit};
    assign q_bit   = (p_shift >= {1'b0, D});
    assign P_out   = q_bit ? (p_shift - {1'b0, D}) : p_shift;

endmodule

// File: rtl/div_16x8_seq.sv
// Radix-2 sequential restoring divider: one quotient bit per clock,
// start/done handshake, all-ones result with div_zero flag when D is zero.
module div_16x8_seq
    import div_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] N,
    input  logic [D_W-1:0] D,
    output logic [N_W-1:0] Q,
    output logic [D_W-1:0] Rm,
    output logic           busy,
    output logic           done,
    output logic           div_zero
);

    localparam int CW = $clog2(N_W);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N_W-1:0] n_q, n_d;       // dividend shifting out, quotient shifting in
    logic [D_W-1:0] dv_q, dv_d;
    logic [D_W:0]   p_q, p_d;
    logic [N_W-1:0] q_q, q_d;
    logic [D_W-1:0] rm_q, rm_d;
    logic           dz_q, dz_d;

    logic [D_W:0]   step_p;
    logic           step_q;

    div_step #(.D_W(D_W)) u_step (
        .P_in  (p_q),
        .n_bit (n_q[N_W-1]),
        .D     (dv_q),
        .P_out (step_p),
        .q_bit (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        dv_d    = dv_q;
        p_d     = p_q;
        q_d     = q_q;
        rm_d    = rm_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (D != '0) begin
                        state_d = CALC;
                        n_d     = N;
                        dv_d    = D;
                        p_d     = '0;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                    end else begin
                        state_d = DONE;
                        q_d     = Q_DZ;
                        rm_d    = R_DZ;
                        dz_d    = 1'b1;
                    end
                end
            end
            CALC: begin
                p_d   = step_p;
                n_d   = {n_q[N_W-2:0], step_q};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N_W - 1)) begin
                    state_d = DONE;
                    q_d     = {n_q[N_W-2:0], step_q};
                    rm_d    = step_p[D_W-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            dv_q    <= '0;
            p_q     <= '0;
            q_q     <= '0;
            rm_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            dv_q    <= dv_d;
            p_q     <= p_d;
            q_q     <= q_d;
            rm_q    <= rm_d;
            dz_q    <= dz_d;
        end
    end

    assign Q        = q_q;
    assign Rm       = rm_q;
    assign div_zero = dz_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: doc/div_16x8_seq.md
# div_16x8_seq

Sequential restoring divider: 16-bit dividend by 8-bit divisor, producing a 16-bit quotient and 8-bit remainder. It is the inverse-operation companion to the 8x8 multiplier library. It serves as the reference divider for multiplier round-trip checks (R = A*B, then R/B recovers A). It also provides the division datapath for error-metric units. It is a radix-2 iterative engine with a start/done handshake, one quotient bit per clock.

## Interface
- N_W, 16, dividend and quotient width
- D_W, 8, divisor and remainder width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request; accepted only in IDLE
- N  in  N_W  dividend, sampled on the accepting edge
- D  in  D_W  divisor, sampled on the accepting edge
- Q  out  N_W  quotient, registered
- Rm  out  D_W  remainder, registered
- busy  out  1  high while an operation is in flight (CALC and DONE)
- done  out  1  one-cycle pulse; Q/Rm/div_zero valid
- div_zero  out  1  D was 0 for the completed operation

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE→CALC: start=1 and D≠0. Latch N into the shift register and D into the divisor register. Clear the partial remainder (D_W+1 bits) and set cnt=0.
  - IDLE→DONE: start=1 and D=0. Q=16'hFFFF, Rm=8'hFF, div_zero=1. No iteration.
  - CALC, each cycle, in order:
    - Shift {P, Nreg} left by 1.
    - If P ≥ Dreg then P -= Dreg and shift in quotient bit 1, else shift in 0.
    - cnt++.
    - After the cycle with cnt=N_W-1, go to DONE.
  - DONE: drive Q from the quotient register, Rm=P[D_W-1:0], and done=1. Next edge always goes to IDLE.
- Partial remainder is D_W+1 bits wide, so there is no compare overflow. After the final step P < D always holds.
- Q, Rm and div_zero hold their values from DONE until the next accepted start. div_zero clears on the next accepted start with D≠0.
- start is ignored in CALC and DONE. There is no queueing.
- N and D may change freely after acceptance; they have no effect on the operation in flight.
- Results are exact for all inputs: N = Q*D + Rm and Rm < D when D≠0.

## Timing
- Reset values: state=IDLE, Q=0, Rm=0, busy=0, done=0, div_zero=0, cnt=0.
- rst has priority over all activity. Reset mid-CALC aborts the operation; outputs take reset values on the next edge and no done is issued.
- Normal latency: start sampled high in IDLE at edge t. CALC occupies cycles t+1..t+16. done=1 in cycle t+17. The FSM is back in IDLE in cycle t+18, where a new start is accepted.
  - Throughput: one divide per 18 cycles.
- Divide-by-zero latency: done=1 in cycle t+1; IDLE in t+2.
- busy=1 from cycle t+1 through the done cycle inclusive. busy=0 in IDLE.
- done is never high for more than one consecutive cycle.

## Structure
- Package div_pkg holds:
  - state enum (IDLE, CALC, DONE)
  - N_W/D_W defaults
  - counter width localparam $clog2(N_W)
  - divide-by-zero constants Q_DZ='1 and R_DZ='1
- One sub-module: div_step. It is a combinational single restoring step:
  - inputs: P_in[D_W:0], next dividend bit, D
  - outputs: P_out[D_W:0], q_bit
  - instantiated once inside the iteration loop
- Top level holds the FSM, counter, operand/shift registers and output registers.

## Test plan
- N=1000, D=7, start 1 cycle → done at t+17 with Q=142, Rm=6, div_zero=0; busy high for t+1..t+17.
- N=65535, D=255 → Q=257, Rm=0. N=0, D=5 → Q=0, Rm=0. N=300, D=1 → Q=300, Rm=0.
- N=1234, D=0 → done at t+1, Q=16'hFFFF, Rm=8'hFF, div_zero=1. A following divide 10/3 → Q=3, Rm=1, div_zero=0.
- Pulse start with N=50, D=9. Pulse start again at t+5 with N=99, D=2, and change N/D every cycle → the single done gives Q=5, Rm=5.
- Assert rst at t+8 of a 40000/200 divide → all outputs reset the next cycle, no done. A new 40000/200 started after reset → Q=200, Rm=0.
- Multiplier round-trip: 10k random A,B with B≠0 and exact R=A*B; divide R by B → Q=A, Rm=0. Random N, D≠0 → N==Q*D+Rm and Rm<D.
